counter_load_sched: RTL and testbench
=====================================

Name: counter_load_sched

Overview:
- Round-robin scheduler that shares one 8-bit loadable up-counter (up_counter_load) among NREQ requesters.
- Each requester asks for a count run from a start value to an end value.
- The block grants one requester at a time, loads the counter, enables it until it reaches the end value, then returns a one-cycle done pulse to that requester.
- Sits directly beside the counter instance and drives its data/load/enable/reset inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, counter/data width; must match the counter instance

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
req  in  NREQ  per-requester request, level; held until done
start_val  in  NREQ*W  flattened start values, slice i = [i*W +: W]
end_val  in  NREQ*W  flattened end values, same slicing
pause  in  1  holds the counter (enable low) while in RUN
grant  out  NREQ  one-hot owner of the counter; zero when idle
done  out  NREQ  one-cycle completion pulse to the owner
busy  out  1  high in LOAD/RUN/DONE
cnt_out  in  W  counter value fed back from the counter
cnt_data  out  W  counter parallel-load data
cnt_load  out  1  counter load enable
cnt_enable  out  1  counter count enable
cnt_reset  out  1  counter reset (active-high) = ~reset, combinational

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE, rr_ptr=0, grant=0, done=0, busy=0, cnt_load=0, cnt_enable=0, cnt_data=0.
  - cnt_reset=1 while reset low.
  - Reset mid-run aborts the run: no done pulse, counter cleared.
- States: IDLE, LOAD, RUN, DONE. All outputs except cnt_reset and cnt_enable are registered.
- IDLE:
  - If any req is high: pick the first set bit searching upward from rr_ptr, with wrap.
  - Latch idx, start_q=start_val[idx], end_q=end_val[idx]; grant<=onehot(idx); go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle): cnt_load=1, cnt_data=start_q, cnt_enable=0; go to RUN.
- RUN:
  - cnt_out==end_q: cnt_enable=0; go to DONE.
  - Otherwise: cnt_enable = ~pause. cnt_enable is combinational on cnt_out/pause/state, so the counter stops exactly at end_q with no overshoot.
  - First RUN cycle sees cnt_out==start_q because the counter has one-cycle load latency.
- DONE (1 cycle):
  - done[idx]=1, grant held; rr_ptr<=(idx+1) mod NREQ; go to IDLE. grant clears on entry to IDLE.
  - Earliest re-grant is in the IDLE cycle after DONE, so there is always one idle bubble between runs.
- Run length:
  - Enabled cycles = (end_q - start_q) mod 2^W.
  - end<start wraps through 2^W-1 -> 0.
  - start==end gives zero enabled cycles: LOAD, RUN, DONE = 3 cycles total.
- Latency, request to done (no pause): 1 (IDLE) + 1 (LOAD) + ((end-start) mod 2^W) + 1 (RUN compare) + 1 (DONE).
- Requester behaviour during a run:
  - Dropping req is ignored; the run completes and done still pulses.
  - start/end changes after grant are ignored (values were latched).
  - A requester that keeps req high after done is re-arbitrated behind the others.
- Simultaneous requests: round-robin, with rr_ptr giving lowest-index priority starting at the pointer. No requester starves; worst-case wait is NREQ-1 runs.
- pause is ignored outside RUN. In RUN with cnt_out==end_q, completion proceeds regardless of pause.
- Invariants:
  - cnt_load and cnt_enable are never both high.
  - grant and done are one-hot or zero.
  - done implies grant of the same bit.

Decomposition:
- Package counter_sched_pkg: state enum typedef (IDLE, LOAD, RUN, DONE; 2-bit) and a default width constant CNT_W=8.
- One sub-module: rr_pick — combinational round-robin selector. Inputs req and ptr; outputs valid, idx, onehot. Parameterised by NREQ.
- The counter itself stays a separate instance outside this block.

Test Plan:
- Reset held low 3 cycles mid-RUN, then released → grant=0, done=0, cnt_reset=1 during reset; first IDLE after release with no req keeps busy=0.
- req=0001, start=10, end=15 → cnt_load pulses once with cnt_data=10. cnt_enable is high exactly 5 cycles; the counter model reads 15; done[0] is pulsed 9 cycles after req.
- req=1111, all start=0, end=2 → done order 0,1,2,3, then 0 again if req is held. One idle cycle with grant=0 between runs.
- start=250, end=3 → wrap: 9 enabled cycles, cnt_out sequence 250..255,0..3, done pulses.
- start==end=77 → zero enable cycles; done is pulsed in the 3rd cycle after grant.
- pause high for 4 cycles mid-RUN (start=0, end=6), and req dropped during the run → enable low exactly during the pause; completes at 6 with run stretched by 4 cycles; done still pulses.

Source files
------------

// File: rtl/counter_load_sched_pkg.sv
// Shared types for the round-robin counter scheduler.
// Holds the FSM state encoding and the default counter width.
package counter_sched_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/counter_load_sched_if.sv
// Requester and counter-side signals of the scheduler.
// Modport slave is the scheduler; modport master is the requesters plus the counter.
interface counter_load_sched_if
   import counter_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = CNT_W
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] start_val;
   logic [NREQ*W-1:0] end_val;
   logic              pause;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [W-1:0]      cnt_out;
   logic [W-1:0]      cnt_data;
   logic              cnt_load;
   logic              cnt_enable;
   logic              cnt_reset;

   modport master (
      output req, start_val, end_val, pause, cnt_out,
      input  grant, done, busy, cnt_data, cnt_load, cnt_enable, cnt_reset
   );

   modport slave (
      input  req, start_val, end_val, pause, cnt_out,
      output grant, done, busy, cnt_data, cnt_load, cnt_enable, cnt_reset
   );
endinterface

// File: rtl/counter_load_sched_rr_pick.sv
// Combinational round-robin selector: first set req bit searching upward from ptr, with wrap.
// Zero latency; valid low when no request is pending.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            valid,
   output logic [IW-1:0]   idx,
   output logic [NREQ-1:0] onehot
);
   int slot;

   // Scan from the farthest offset down so the nearest hit to ptr wins.
   always_comb begin
      valid  = 1'b0;
      idx    = '0;
      onehot = '0;
      slot   = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         slot = int'(ptr) + i;
         if (slot >= NREQ) slot = slot - NREQ;
         if (req[slot[IW-1:0]]) begin
            valid = 1'b1;
            idx   = slot[IW-1:0];
         end
      end
      if (valid) onehot[idx] = 1'b1;
   end
endmodule

// File: rtl/counter_load_sched.sv
// Round-robin owner of one loadable up-counter: IDLE -> LOAD -> RUN -> DONE per run.
// Latency req->done = 4 + (end-start) mod 2^W cycles plus paused cycles; requesters hold req until done.
module counter_load_sched
   import counter_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = CNT_W
) (
   input logic                 clk,
   input logic                 reset,
   counter_load_sched_if.slave bus
);
   localparam int IW = $clog2(NREQ);

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   idx_q;
   logic [W-1:0]    end_q;
   logic [W-1:0]    data_q;
   logic [NREQ-1:0] grant_q;
   logic [NREQ-1:0] done_q;
   logic            busy_q;
   logic            load_q;

   logic            pick_vld;
   logic [IW-1:0]   pick_idx;
   logic [NREQ-1:0] pick_oh;
   logic [W-1:0]    start_arr [NREQ];
   logic [W-1:0]    end_arr   [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign start_arr[g] = bus.start_val[g*W +: W];
      assign end_arr[g]   = bus.end_val[g*W +: W];
   end

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req    (bus.req),
      .ptr    (rr_ptr),
      .valid  (pick_vld),
      .idx    (pick_idx),
      .onehot (pick_oh)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         idx_q   <= '0;
         end_q   <= '0;
         data_q  <= '0;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  idx_q   <= pick_idx;
                  data_q  <= start_arr[pick_idx];
                  end_q   <= end_arr[pick_idx];
                  grant_q <= pick_oh;
                  busy_q  <= 1'b1;
                  load_q  <= 1'b1;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               load_q <= 1'b0;
               state  <= RUN;
            end
            RUN: begin
               if (bus.cnt_out == end_q) begin
                  done_q <= grant_q;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q  <= '0;
               grant_q <= '0;
               busy_q  <= 1'b0;
               rr_ptr  <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Enable is combinational so the counter stops exactly on end_q.
   assign bus.cnt_enable = (state == RUN) && (bus.cnt_out != end_q) && !bus.pause;
   assign bus.cnt_reset  = ~reset;
   assign bus.cnt_load   = load_q;
   assign bus.cnt_data   = data_q;
   assign bus.grant      = grant_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_counter_load_sched.sv
// Directed bench for counter_load_sched with a behavioural loadable counter beside it.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_counter_load_sched;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   counter_load_sched_if #(.NREQ(4), .W(8)) bus ();

   counter_load_sched #(.NREQ(4), .W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Loadable up-counter with one-cycle load latency.
   always_ff @(posedge clk) begin
      if (bus.cnt_reset)       bus.cnt_out <= 8'd0;
      else if (bus.cnt_load)   bus.cnt_out <= bus.cnt_data;
      else if (bus.cnt_enable) bus.cnt_out <= bus.cnt_out + 8'd1;
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_rq(input int i, input logic [7:0] s, input logic [7:0] e);
      bus.start_val[i*8 +: 8] = s;
      bus.end_val[i*8 +: 8]   = e;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      int done_seen;
      reset = 1'b0;
      bus.req = 4'b0000;
      bus.pause = 1'b0;
      bus.start_val = '0;
      bus.end_val = '0;
      cyc();
      cyc();
      checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
      checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b exp=0000", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.cnt_load !== 1'b0 || bus.cnt_enable !== 1'b0) begin errors++; $display("FAIL reset_ld_en got=%b%b exp=00", bus.cnt_load, bus.cnt_enable); end
      checks++; if (bus.cnt_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", bus.cnt_data); end
      checks++; if (bus.cnt_reset !== 1'b1) begin errors++; $display("FAIL reset_cnt_reset got=%b exp=1", bus.cnt_reset); end
      reset = 1'b1;
      #1;
      checks++; if (bus.cnt_reset !== 1'b0) begin errors++; $display("FAIL release_cnt_reset got=%b exp=0", bus.cnt_reset); end
      cyc();
      // Start a long run, then reset while it is counting.
      set_rq(0, 8'd0, 8'd200);
      bus.req = 4'b0001;
      for (int k = 0; k < 4; k++) cyc();
      checks++; if (bus.busy !== 1'b1 || bus.cnt_enable !== 1'b1) begin errors++; $display("FAIL midrun_active got=%b%b exp=11", bus.busy, bus.cnt_enable); end
      reset = 1'b0;
      #1;
      checks++; if (bus.cnt_reset !== 1'b1) begin errors++; $display("FAIL midrun_cnt_reset got=%b exp=1", bus.cnt_reset); end
      done_seen = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (bus.done !== 4'b0000) done_seen++;
         checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL midrun_grant got=%b exp=0000", bus.grant); end
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL midrun_done got=%0d pulses exp=0", done_seen); end
      bus.req = 4'b0000;
      reset = 1'b1;
      cyc();
      checks++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin errors++; $display("FAIL post_reset_idle got=%b/%b exp=0/0000", bus.busy, bus.grant); end
      checks++; if (bus.cnt_out !== 8'd0) begin errors++; $display("FAIL post_reset_cnt got=%0d exp=0", bus.cnt_out); end
   endtask

   task automatic test_single();
      int edges = 0, loads = 0, en = 0, got = 0;
      logic [7:0] ld_data = 8'd0;
      logic [3:0] dv = 4'b0;
      set_rq(0, 8'd10, 8'd15);
      bus.req = 4'b0001;
      while (!got && edges < 40) begin
         cyc();
         edges++;
         if (bus.cnt_load === 1'b1) begin loads++; ld_data = bus.cnt_data; end
         if (bus.cnt_enable === 1'b1) en++;
         if (bus.done !== 4'b0000) begin got = 1; dv = bus.done; end
      end
      checks++; if (loads != 1) begin errors++; $display("FAIL single_loads got=%0d exp=1", loads); end
      checks++; if (ld_data !== 8'd10) begin errors++; $display("FAIL single_load_data got=%0d exp=10", ld_data); end
      checks++; if (en != 5) begin errors++; $display("FAIL single_enables got=%0d exp=5", en); end
      checks++; if (dv !== 4'b0001) begin errors++; $display("FAIL single_done got=%b exp=0001", dv); end
      // IDLE cycle counts as the first of nine, so done is seen 8 edges later.
      checks++; if (edges != 8) begin errors++; $display("FAIL single_latency got=%0d exp=8", edges); end
      checks++; if (bus.cnt_out !== 8'd15) begin errors++; $display("FAIL single_final_cnt got=%0d exp=15", bus.cnt_out); end
      bus.req = 4'b0000;
      cyc();
   endtask

   task automatic test_rr();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int n = 0, edges = 0, last = 0, di;
      logic bubble = 1'b0;
      pulse_reset();
      for (int i = 0; i < 4; i++) set_rq(i, 8'd0, 8'd2);
      bus.req = 4'b1111;
      while (n < 5 && edges < 100) begin
         cyc();
         edges++;
         if (bubble) begin
            bubble = 1'b0;
            checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL rr_bubble got=%b/%b exp=0000/0", bus.grant, bus.busy); end
         end
         if (bus.done !== 4'b0000) begin
            di = -1;
            for (int k = 0; k < 4; k++) if (bus.done[k]) di = k;
            checks++; if (!$onehot(bus.done) || di != exp_order[n]) begin errors++; $display("FAIL rr_order[%0d] got=%b exp=%0d", n, bus.done, exp_order[n]); end
            if (n > 0) begin
               checks++; if (edges - last != 6) begin errors++; $display("FAIL rr_gap[%0d] got=%0d exp=6", n, edges - last); end
            end
            last = edges;
            n++;
            bubble = 1'b1;
         end
      end
      checks++; if (n != 5) begin errors++; $display("FAIL rr_count got=%0d exp=5", n); end
      bus.req = 4'b0000;
      cyc();
   endtask

   task automatic test_wrap();
      int edges = 0, en = 0, got = 0;
      logic [7:0] expv;
      logic [3:0] dv = 4'b0;
      set_rq(2, 8'd250, 8'd3);
      bus.req = 4'b0100;
      while (!got && edges < 40) begin
         cyc();
         edges++;
         if (bus.cnt_enable === 1'b1) begin
            expv = 8'd250 + 8'(en);
            checks++; if (bus.cnt_out !== expv) begin errors++; $display("FAIL wrap_seq[%0d] got=%0d exp=%0d", en, bus.cnt_out, expv); end
            en++;
         end
         if (bus.done !== 4'b0000) begin got = 1; dv = bus.done; end
      end
      checks++; if (en != 9) begin errors++; $display("FAIL wrap_enables got=%0d exp=9", en); end
      checks++; if (dv !== 4'b0100) begin errors++; $display("FAIL wrap_done got=%b exp=0100", dv); end
      checks++; if (edges != 12) begin errors++; $display("FAIL wrap_latency got=%0d exp=12", edges); end
      checks++; if (bus.cnt_out !== 8'd3) begin errors++; $display("FAIL wrap_final_cnt got=%0d exp=3", bus.cnt_out); end
      bus.req = 4'b0000;
      cyc();
   endtask

   task automatic test_equal();
      int e = 0, en = 0, got = 0;
      logic [3:0] dv = 4'b0;
      set_rq(3, 8'd77, 8'd77);
      bus.req = 4'b1000;
      cyc();
      checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL equal_grant got=%b exp=1000", bus.grant); end
      checks++; if (bus.cnt_load !== 1'b1 || bus.cnt_data !== 8'd77) begin errors++; $display("FAIL equal_load got=%b/%0d exp=1/77", bus.cnt_load, bus.cnt_data); end
      while (!got && e < 10) begin
         cyc();
         e++;
         if (bus.cnt_enable === 1'b1) en++;
         if (bus.done !== 4'b0000) begin got = 1; dv = bus.done; end
      end
      checks++; if (en != 0) begin errors++; $display("FAIL equal_enables got=%0d exp=0", en); end
      // Grant cycle is the first, done lands in the third.
      checks++; if (e != 2) begin errors++; $display("FAIL equal_latency got=%0d exp=2", e); end
      checks++; if (dv !== 4'b1000) begin errors++; $display("FAIL equal_done got=%b exp=1000", dv); end
      bus.req = 4'b0000;
      cyc();
   endtask

   task automatic test_pause();
      int k = 0, en = 0, got = 0;
      logic [3:0] dv = 4'b0;
      set_rq(1, 8'd0, 8'd6);
      bus.req = 4'b0010;
      while (!got && k < 60) begin
         cyc();
         k++;
         if (k == 4) bus.pause = 1'b1;
         if (k == 5) bus.req = 4'b0000;
         if (k == 8) bus.pause = 1'b0;
         #1;
         if (bus.pause) begin
            checks++; if (bus.cnt_enable !== 1'b0) begin errors++; $display("FAIL pause_enable[%0d] got=%b exp=0", k, bus.cnt_enable); end
         end
         if (bus.cnt_enable === 1'b1) en++;
         if (bus.done !== 4'b0000) begin got = 1; dv = bus.done; end
      end
      checks++; if (en != 6) begin errors++; $display("FAIL pause_enables got=%0d exp=6", en); end
      checks++; if (dv !== 4'b0010) begin errors++; $display("FAIL pause_done got=%b exp=0010", dv); end
      checks++; if (k != 13) begin errors++; $display("FAIL pause_latency got=%0d exp=13", k); end
      checks++; if (bus.cnt_out !== 8'd6) begin errors++; $display("FAIL pause_final_cnt got=%0d exp=6", bus.cnt_out); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr();
      test_wrap();
      test_equal();
      test_pause();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
